// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug run controller:
//   - UART command byte codes
//   - run/dump FSM state encoding
//   - dump section encoding and the word-index -> section helper
//   - byte extraction helper (big-endian byte order, byte 0 = bits 31:24)
// -----------------------------------------------------------------------------
package debug_pkg;

  localparam logic [7:0] CMD_CONT = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'
  localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

  typedef enum logic [2:0] {
    HALTED  = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    SETUP   = 3'd3,
    WAIT    = 3'd4,
    CAPTURE = 3'd5,
    SEND    = 3'd6,
    ACK     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    SEC_PC    = 2'd0,
    SEC_LATCH = 2'd1,
    SEC_REG   = 2'd2,
    SEC_MEM   = 2'd3
  } section_e;

  // Map a dump word index onto its section: PC first, then the latch words,
  // then the register file, then data memory.
  function automatic section_e section_of(input int unsigned w,
                                          input int unsigned num_latch,
                                          input int unsigned num_regs);
    section_e sec;
    if (w == 32'd0) begin
      sec = SEC_PC;
    end else if (w <= num_latch) begin
      sec = SEC_LATCH;
    end else if (w <= (num_latch + num_regs)) begin
      sec = SEC_REG;
    end else begin
      sec = SEC_MEM;
    end
    return sec;
  endfunction

  // Select byte b of a word, b = 0 being the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word,
                                           input logic [1:0]  b);
    logic [7:0] res;
    case (b)
      2'd0:    res = word[31:24];
      2'd1:    res = word[23:16];
      2'd2:    res = word[15:8];
      2'd3:    res = word[7:0];
      default: res = 8'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/debug_run_controller_if.sv
// -----------------------------------------------------------------------------
// debug_run_controller_if
// Bundles everything the debug run controller exchanges with the pipeline and
// the UART:
//   UART RX    : cmd_valid, cmd_byte
//   UART TX    : tx_start, tx_data, tx_done
//   pipeline   : halt_detected, pc_in, stop_debug, busy
//   debug read : debug_addr, latch_sel, latch_data, fr_data, mem_data
// modport master = the controller, modport slave = its environment.
// -----------------------------------------------------------------------------
interface debug_run_controller_if;

  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        halt_detected;
  logic [31:0] pc_in;
  logic [31:0] latch_data;
  logic [31:0] fr_data;
  logic [31:0] mem_data;
  logic        tx_done;

  logic        stop_debug;
  logic [31:0] debug_addr;
  logic [6:0]  latch_sel;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_byte, halt_detected, pc_in,
           latch_data, fr_data, mem_data, tx_done,
    output stop_debug, debug_addr, latch_sel, tx_start, tx_data, busy
  );

  modport slave (
    output cmd_valid, cmd_byte, halt_detected, pc_in,
           latch_data, fr_data, mem_data, tx_done,
    input  stop_debug, debug_addr, latch_sel, tx_start, tx_data, busy
  );

endinterface

// File: rtl/debug_word_serializer.sv
// -----------------------------------------------------------------------------
// debug_word_serializer
// Holds one captured 32-bit word and sends it as four bytes, MSB first,
// using a tx_start / tx_done handshake with the UART transmitter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture word_in and restart at byte 0
//   word_in      word to serialize
//   send         registered tx_start is raised next cycle for the current byte
//   ack_active   controller is waiting for the UART; tx_done counts only here
//   tx_done      UART finished the current byte
//   tx_start     one-cycle start pulse (registered)
//   tx_data      byte being sent, held until the next send (registered)
//   byte_done    a byte was acknowledged this cycle
//   word_done    the last byte of the word was acknowledged this cycle
// -----------------------------------------------------------------------------
module debug_word_serializer
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        send,
  input  logic        ack_active,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        byte_done,
  output logic        word_done
);

  logic [31:0] buf_q, buf_d;
  logic [1:0]  b_q, b_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;

  // Acknowledge decode: tx_done only matters while the controller is in ACK.
  always_comb begin
    byte_done = ack_active & tx_done;
    word_done = ack_active & tx_done & (b_q == 2'd3);
  end

  // Next buffer, byte index and transmit outputs.
  always_comb begin
    buf_d = buf_q;
    b_d   = b_q;
    if (load) begin
      buf_d = word_in;
      b_d   = 2'd0;
    end else if (byte_done && (b_q != 2'd3)) begin
      b_d = b_q + 2'd1;
    end else begin
      b_d = b_q;
    end
    // Use the next-state buffer/index so the first byte is correct in the
    // same cycle the word is loaded.
    tx_start_d = send;
    if (send) begin
      tx_data_d = word_byte(buf_d, b_d);
    end else begin
      tx_data_d = tx_data_q;
    end
  end

  // Serializer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= 32'd0;
      b_q        <= 2'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
    end else begin
      buf_q      <= buf_d;
      b_q        <= b_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/debug_run_controller.sv
// -----------------------------------------------------------------------------
// debug_run_controller
// Controls the MIPS pipeline freeze for the debug unit (halted, continuous run,
// single step) from UART command bytes, and after a step or halt dumps machine
// state over the UART: PC, stage latches, register file, data memory, each word
// as four big-endian bytes.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    debug_run_controller_if.master (commands, pipeline, debug read
//          port and UART TX handshake)
// -----------------------------------------------------------------------------
module debug_run_controller
  import debug_pkg::*;
#(
  parameter int NUM_LATCH     = 8,
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 16,
  parameter int SEL_LAT       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  debug_run_controller_if.master bus
);

  localparam int TOTAL  = 1 + NUM_LATCH + NUM_REGS + NUM_MEM_WORDS;
  localparam int W_W    = $clog2(TOTAL);
  localparam int WAIT_W = (SEL_LAT > 1) ? $clog2(SEL_LAT) : 1;
  localparam logic [W_W-1:0]    W_LAST    = W_W'(TOTAL - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((SEL_LAT > 0) ? (SEL_LAT - 1) : 0);

  state_e              state_q, state_d;
  logic [W_W-1:0]      w_q, w_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                stop_debug_q, stop_debug_d;
  logic                busy_q, busy_d;
  logic [31:0]         debug_addr_q, debug_addr_d;
  logic [6:0]          latch_sel_q, latch_sel_d;

  logic [31:0]         capture_word;
  logic                byte_done;
  logic                word_done;
  logic                ser_tx_start;
  logic [7:0]          ser_tx_data;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the word index and select-latency counter.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    wait_d  = wait_q;
    case (state_q)
      HALTED: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_byte)
            CMD_CONT: state_d = RUN;
            CMD_STEP: state_d = STEP;
            CMD_DUMP: begin
              state_d = SETUP;
              w_d     = '0;
            end
            default:  state_d = HALTED;
          endcase
        end else begin
          state_d = HALTED;
        end
      end
      RUN: begin
        // halt_detected takes priority over a simultaneous 'h'.
        if (bus.halt_detected) begin
          state_d = SETUP;
          w_d     = '0;
        end else if (bus.cmd_valid && (bus.cmd_byte == CMD_HALT)) begin
          state_d = HALTED;
        end else begin
          state_d = RUN;
        end
      end
      STEP: begin
        state_d = SETUP;
        w_d     = '0;
      end
      SETUP: begin
        wait_d = '0;
        if (SEL_LAT > 0) begin
          state_d = WAIT;
        end else begin
          state_d = CAPTURE;
        end
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = CAPTURE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      CAPTURE: state_d = SEND;
      SEND:    state_d = ACK;
      ACK: begin
        if (word_done) begin
          if (w_q == W_LAST) begin
            state_d = HALTED;
          end else begin
            w_d     = w_q + W_W'(1);
            state_d = SETUP;
          end
        end else if (byte_done) begin
          state_d = SEND;
        end else begin
          state_d = ACK;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  // Output logic: registered outputs follow the next state, so stop_debug
  // rises on the same edge that leaves RUN/STEP.
  always_comb begin
    logic [31:0] w_ext;
    w_ext        = 32'(w_d);
    stop_debug_d = !((state_d == RUN) || (state_d == STEP));
    busy_d       = !((state_d == HALTED) || (state_d == RUN));
    debug_addr_d = debug_addr_q;
    latch_sel_d  = latch_sel_q;
    if (state_d == SETUP) begin
      // Each select only moves inside its own section and holds elsewhere.
      case (section_of(w_ext, NUM_LATCH, NUM_REGS))
        SEC_LATCH: latch_sel_d  = 7'(w_ext - 32'd1);
        SEC_REG:   debug_addr_d = w_ext - 32'(1 + NUM_LATCH);
        SEC_MEM:   debug_addr_d = w_ext - 32'(1 + NUM_LATCH + NUM_REGS);
        default: begin
          debug_addr_d = debug_addr_q;
          latch_sel_d  = latch_sel_q;
        end
      endcase
    end else begin
      debug_addr_d = debug_addr_q;
      latch_sel_d  = latch_sel_q;
    end
  end

  // Source mux for the word captured in CAPTURE.
  always_comb begin
    case (section_of(32'(w_q), NUM_LATCH, NUM_REGS))
      SEC_PC:    capture_word = bus.pc_in;
      SEC_LATCH: capture_word = bus.latch_data;
      SEC_REG:   capture_word = bus.fr_data;
      SEC_MEM:   capture_word = bus.mem_data;
      default:   capture_word = 32'd0;
    endcase
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q          <= '0;
      wait_q       <= '0;
      stop_debug_q <= 1'b1;
      busy_q       <= 1'b0;
      debug_addr_q <= 32'd0;
      latch_sel_q  <= 7'd0;
    end else begin
      w_q          <= w_d;
      wait_q       <= wait_d;
      stop_debug_q <= stop_debug_d;
      busy_q       <= busy_d;
      debug_addr_q <= debug_addr_d;
      latch_sel_q  <= latch_sel_d;
    end
  end

  debug_word_serializer u_serializer (
    .clk        (clk),
    .rst_n      (reset),
    .load       (state_q == CAPTURE),
    .word_in    (capture_word),
    .send       (state_d == SEND),
    .ack_active (state_q == ACK),
    .tx_done    (bus.tx_done),
    .tx_start   (ser_tx_start),
    .tx_data    (ser_tx_data),
    .byte_done  (byte_done),
    .word_done  (word_done)
  );

  assign bus.stop_debug = stop_debug_q;
  assign bus.busy       = busy_q;
  assign bus.debug_addr = debug_addr_q;
  assign bus.latch_sel  = latch_sel_q;
  assign bus.tx_start   = ser_tx_start;
  assign bus.tx_data    = ser_tx_data;

endmodule

// File: tb/tb_debug_run_controller.sv
// -----------------------------------------------------------------------------
// tb_debug_run_controller
// Directed, self-checking bench for debug_run_controller. A small responder
// answers each tx_start with tx_done ten cycles later and records every byte;
// debug read sources return tagged words so the dumped bytes identify which
// address/select was used.
// -----------------------------------------------------------------------------
module tb_debug_run_controller;

  localparam int TOTAL_BYTES = 228;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debug_run_controller_if bus ();

  debug_run_controller #(
    .NUM_LATCH     (8),
    .NUM_REGS      (32),
    .NUM_MEM_WORDS (16),
    .SEL_LAT       (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Responder / recorder state. Test tasks only write hold_byte, spur_en and
  // release_cnt; the responder only writes the rest.
  logic [7:0] bytes [0:4095];
  int  byte_cnt     = 0;
  int  pend         = 0;
  int  spur_left    = 0;
  bit  holding      = 1'b0;
  int  hold_byte    = -1;
  bit  spur_en      = 1'b0;
  int  release_cnt  = 0;
  int  release_seen = 0;

  // Debug read sources with one cycle of select-to-data latency.
  always @(posedge clk) begin
    bus.latch_data <= 32'hA000_0000 | {25'd0, bus.latch_sel};
    bus.fr_data    <= 32'hB000_0000 | {27'd0, bus.debug_addr[4:0]};
    bus.mem_data   <= 32'hC000_0000 | bus.debug_addr;
  end

  // UART TX model: acts 1 time unit after each rising edge.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
      if (spur_left > 0) begin
        bus.tx_done = 1'b1;
        spur_left--;
      end
      if (!reset) begin
        pend      = 0;
        holding   = 1'b0;
        spur_left = 0;
        bus.tx_done = 1'b0;
      end else if (bus.tx_start) begin
        if (byte_cnt < 4096) bytes[byte_cnt] = bus.tx_data;
        byte_cnt++;
        if (byte_cnt == hold_byte) holding = 1'b1;
        else pend = 10;
      end else if (holding) begin
        if (release_cnt != release_seen) begin
          release_seen = release_cnt;
          holding      = 1'b0;
          bus.tx_done  = 1'b1;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.tx_done = 1'b1;
          // After a word's last byte, keep tx_done up through SETUP and WAIT.
          if (spur_en && (byte_cnt % 4 == 0)) spur_left = 2;
        end
      end
    end
  end

  function automatic logic [31:0] exp_word(input int w, input logic [31:0] pc);
    if (w == 0)       return pc;
    else if (w <= 8)  return 32'hA000_0000 | 32'(w - 1);
    else if (w <= 40) return 32'hB000_0000 | 32'(w - 9);
    else              return 32'hC000_0000 | 32'(w - 41);
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = 8'h00;
  endtask

  task automatic run_until_idle(input string name, output int low);
    int cyc;
    low = 0;
    cyc = 0;
    while (bus.busy && cyc < 8000) begin
      if (!bus.stop_debug) low++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, bus.busy, cyc);
    end
  endtask

  task automatic check_dump(input string name, input int base, input logic [31:0] pc);
    int bad;
    logic [31:0] ew;
    logic [7:0]  eb;
    logic [7:0]  got;
    bad = -1;
    eb  = 8'h00;
    got = 8'h00;
    checks++;
    if (byte_cnt - base != TOTAL_BYTES) begin
      failures++;
      $display("FAIL %s_count: bytes=%0d expected %0d", name, byte_cnt - base, TOTAL_BYTES);
    end
    for (int w = 0; w < 57; w++) begin
      ew = exp_word(w, pc);
      for (int b = 0; b < 4; b++) begin
        if (bad < 0 && (bytes[base + 4*w + b] !== ew[8*(3-b) +: 8])) begin
          bad = 4*w + b;
          eb  = ew[8*(3-b) +: 8];
          got = bytes[base + 4*w + b];
        end
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_data: byte %0d = %h expected %h", name, bad, got, eb);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.stop_debug, bus.tx_start, bus.busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl: stop/tx_start/busy=%b expected 100",
               {bus.stop_debug, bus.tx_start, bus.busy});
    end
    checks++;
    if (bus.debug_addr !== 32'd0 || bus.latch_sel !== 7'd0 || bus.tx_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_sel: addr=%h sel=%h data=%h expected 0/0/0",
               bus.debug_addr, bus.latch_sel, bus.tx_data);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stop_debug !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: stop=%b busy=%b expected 1/0", bus.stop_debug, bus.busy);
    end
  endtask

  task automatic test_single_step();
    int base, low;
    bus.pc_in = 32'h0000_0024;
    base = byte_cnt;
    send_cmd(8'h73);
    run_until_idle("step", low);
    checks++;
    if (low != 1) begin
      failures++;
      $display("FAIL step_stop_low: stop_debug low %0d cycles expected 1", low);
    end
    checks++;
    if ({bytes[base], bytes[base+1], bytes[base+2], bytes[base+3]} !== 32'h0000_0024) begin
      failures++;
      $display("FAIL step_pc_bytes: got %h expected 00000024",
               {bytes[base], bytes[base+1], bytes[base+2], bytes[base+3]});
    end
    check_dump("step", base, 32'h0000_0024);
    checks++;
    if (bus.stop_debug !== 1'b1 || bus.debug_addr !== 32'd15 || bus.latch_sel !== 7'd7) begin
      failures++;
      $display("FAIL step_end: stop=%b addr=%0d sel=%0d expected 1/15/7",
               bus.stop_debug, bus.debug_addr, bus.latch_sel);
    end
  endtask

  task automatic test_continuous_run();
    int base, low;
    bus.pc_in = 32'h1000_0040;
    base = byte_cnt;
    send_cmd(8'h63);
    checks++;
    if (bus.stop_debug !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL run_enter: stop=%b busy=%b expected 0/0", bus.stop_debug, bus.busy);
    end
    repeat (49) @(negedge clk);
    bus.halt_detected = 1'b1;
    @(negedge clk);
    bus.halt_detected = 1'b0;
    checks++;
    if (bus.stop_debug !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL run_halt_detect: stop=%b busy=%b expected 1/1", bus.stop_debug, bus.busy);
    end
    run_until_idle("run", low);
    checks++;
    if (low != 0) begin
      failures++;
      $display("FAIL run_dump_stop: stop_debug low %0d cycles in dump expected 0", low);
    end
    check_dump("run", base, 32'h1000_0040);
  endtask

  task automatic test_halt_no_dump();
    int base, low;
    base = byte_cnt;
    send_cmd(8'h63);
    repeat (5) @(negedge clk);
    send_cmd(8'h68);
    checks++;
    if (bus.stop_debug !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL halt_cmd: stop=%b busy=%b expected 1/0", bus.stop_debug, bus.busy);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (byte_cnt != base) begin
      failures++;
      $display("FAIL halt_no_tx: %0d bytes sent expected 0", byte_cnt - base);
    end
    // 'h' together with halt_detected: the halt still dumps.
    send_cmd(8'h63);
    @(negedge clk);
    bus.cmd_valid     = 1'b1;
    bus.cmd_byte      = 8'h68;
    bus.halt_detected = 1'b1;
    @(negedge clk);
    bus.cmd_valid     = 1'b0;
    bus.cmd_byte      = 8'h00;
    bus.halt_detected = 1'b0;
    checks++;
    if (bus.stop_debug !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL halt_both: stop=%b busy=%b expected 1/1", bus.stop_debug, bus.busy);
    end
    run_until_idle("halt_both", low);
    check_dump("halt_both", base, 32'h1000_0040);
  endtask

  task automatic test_backpressure();
    int base, low, cyc, viol;
    logic [7:0] held;
    bus.pc_in = 32'hDEAD_BEEF;
    base = byte_cnt;
    hold_byte = base + 21;
    send_cmd(8'h64);
    cyc = 0;
    while (!holding && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!holding) begin
      failures++;
      $display("FAIL bp_reach: byte 21 not reached after %0d cycles", cyc);
    end
    held = bus.tx_data;
    checks++;
    if (held !== 8'hA0) begin
      failures++;
      $display("FAIL bp_byte: tx_data=%h expected a0", held);
    end
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.tx_start !== 1'b0 || bus.tx_data !== held) viol++;
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d cycles with tx_start or changed tx_data expected 0", viol);
    end
    send_cmd(8'h63);
    send_cmd(8'h73);
    send_cmd(8'h68);
    send_cmd(8'h64);
    checks++;
    if (bus.busy !== 1'b1 || bus.stop_debug !== 1'b1 || byte_cnt - base != 21) begin
      failures++;
      $display("FAIL bp_cmds: busy=%b stop=%b bytes=%0d expected 1/1/21",
               bus.busy, bus.stop_debug, byte_cnt - base);
    end
    hold_byte = -1;
    release_cnt++;
    run_until_idle("bp", low);
    checks++;
    if (low != 0) begin
      failures++;
      $display("FAIL bp_stop: stop_debug low %0d cycles expected 0", low);
    end
    check_dump("bp", base, 32'hDEAD_BEEF);
  endtask

  task automatic test_spurious_done();
    int base, low;
    bus.pc_in = 32'h0040_1000;
    base = byte_cnt;
    spur_en = 1'b1;
    send_cmd(8'h64);
    run_until_idle("spur", low);
    spur_en = 1'b0;
    check_dump("spur", base, 32'h0040_1000);
  endtask

  task automatic test_reset_mid_dump();
    int base, low, cyc;
    bus.pc_in = 32'h8765_4320;
    base = byte_cnt;
    send_cmd(8'h64);
    cyc = 0;
    while (!((byte_cnt - base == 100) && bus.tx_start) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.tx_start !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_reach: byte 100 not in flight after %0d cycles", cyc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.tx_start, bus.stop_debug, bus.busy} !== 3'b010) begin
      failures++;
      $display("FAIL rst_mid_ctrl: tx_start/stop/busy=%b expected 010",
               {bus.tx_start, bus.stop_debug, bus.busy});
    end
    checks++;
    if (bus.debug_addr !== 32'd0 || bus.latch_sel !== 7'd0 || bus.tx_data !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid_sel: addr=%h sel=%h data=%h expected 0/0/0",
               bus.debug_addr, bus.latch_sel, bus.tx_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.stop_debug !== 1'b1 || bus.tx_start !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_release: busy=%b stop=%b tx_start=%b expected 0/1/0",
               bus.busy, bus.stop_debug, bus.tx_start);
    end
    base = byte_cnt;
    send_cmd(8'h64);
    run_until_idle("rst_redump", low);
    check_dump("rst_redump", base, 32'h8765_4320);
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_byte      = 8'h00;
    bus.halt_detected = 1'b0;
    bus.pc_in         = 32'd0;
    test_reset();
    test_single_step();
    test_continuous_run();
    test_halt_no_dump();
    test_backpressure();
    test_spurious_done();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_run_controller.md
Name: debug_run_controller

Overview:
- Sequences the MIPS pipeline for the debug unit. It gates the pipeline freeze signal (stop_debug) for the halted, continuous-run and single-step modes, driven by command bytes from UART RX.
- After a step or a halt it dumps machine state over the UART transmitter as big-endian bytes: PC, stage latches, register file, then data memory.
- While dumping it drives the debug read address and the latch-mux select, and handshakes each byte with the UART TX.

Parameters:
- NUM_LATCH, 8, number of 32-bit latch words read through latch_sel (values 0..NUM_LATCH-1)
- NUM_REGS, 32, register-file words dumped
- NUM_MEM_WORDS, 16, data-memory words dumped, word addresses 0..NUM_MEM_WORDS-1
- SEL_LAT, 1, cycles from a change of debug_addr/latch_sel to valid read data

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  one-cycle strobe: cmd_byte is valid
- cmd_byte  in  8  command from UART RX
- halt_detected  in  1  HALT opcode present in the fetch stage
- pc_in  in  32  current PC
- latch_data  in  32  word selected by latch_sel
- fr_data  in  32  register-file word at debug_addr[4:0]
- mem_data  in  32  data-memory word at debug_addr
- tx_done  in  1  one-cycle pulse: UART finished the current byte
- stop_debug  out  1  1 = pipeline frozen
- debug_addr  out  32  register/memory debug read address
- latch_sel  out  7  latch-mux select
- tx_start  out  1  one-cycle pulse: send tx_data
- tx_data  out  8  byte to transmit
- busy  out  1  high in STEP and all dump states

Behaviour:
- Reset (asynchronous, active-low): state HALTED, stop_debug=1, tx_start=0, tx_data=0, debug_addr=0, latch_sel=0, busy=0, all counters 0. An in-flight byte is abandoned and tx_start falls immediately.
- Commands are decoded only on cmd_valid. Bytes not accepted in the current state are dropped.
  - 0x63 'c': HALTED -> RUN.
  - 0x73 's': HALTED -> STEP.
  - 0x68 'h': RUN -> HALTED, no dump.
  - 0x64 'd': HALTED -> DUMP.
  - Any other byte is ignored.
- HALTED: stop_debug=1.
- RUN: stop_debug=0.
  - halt_detected=1 -> stop_debug=1 on the next edge, go to DUMP.
  - If 'h' and halt_detected occur in the same cycle, halt_detected wins and a dump follows.
- STEP: stop_debug=0 for exactly one clock, then stop_debug=1 and go to DUMP. The pipeline advances one cycle.
- Dump sequence: word index w runs 0..TOTAL-1, with TOTAL = 1 + NUM_LATCH + NUM_REGS + NUM_MEM_WORDS (57 at defaults).
  - Sections in order: PC (w=0), LATCH (latch_sel=w-1), REG (debug_addr=w-1-NUM_LATCH), MEM (debug_addr=w-1-NUM_LATCH-NUM_REGS).
  - debug_addr and latch_sel hold their last values outside their own sections.
- Dump states:
  - SETUP: drive the selects for word w.
  - WAIT: count SEL_LAT cycles.
  - CAPTURE: latch the source word (pc_in, latch_data, fr_data or mem_data) into a 32-bit buffer.
  - SEND: tx_data = buffer byte b (b=0 is bits 31:24), tx_start=1 for one cycle.
  - ACK: hold tx_data; wait for tx_done.
  - On tx_done in ACK: b<3 -> b+1, back to SEND. b=3 and w<TOTAL-1 -> w+1, back to SETUP. Otherwise go to HALTED.
  - tx_done outside ACK is ignored.
  - No timeout: ACK waits indefinitely.
- stop_debug stays 1 for the whole dump. A full dump is exactly 4*TOTAL tx_start pulses (228 at defaults).
- Counter widths: w sized by $clog2(TOTAL); b is 2 bits. Neither wraps: the terminal checks above end the dump first.

Decomposition:
- Shared package debug_pkg:
  - command byte constants CMD_CONT, CMD_STEP, CMD_HALT, CMD_DUMP
  - state enum (HALTED, RUN, STEP, SETUP, WAIT, CAPTURE, SEND, ACK)
  - section enum (SEC_PC, SEC_LATCH, SEC_REG, SEC_MEM)
- One sub-module, debug_word_serializer:
  - loads a 32-bit word, emits 4 bytes MSB first with the tx_start/tx_done handshake, reports word_done.
  - The top FSM owns mode control, indices and select generation.

Test Plan:
- Reset values: assert reset=0 mid-run -> stop_debug=1, tx_start=0, debug_addr=0, latch_sel=0, busy=0 asynchronously. The first clock after release stays HALTED.
- Single step: pc_in=0x00000024, send 's'.
  - stop_debug=0 for exactly 1 cycle.
  - Then 228 tx_start pulses (bench pulses tx_done 10 cycles after each).
  - First four bytes are 00 00 00 24.
  - Controller returns to HALTED with busy=0.
- Continuous run: send 'c', raise halt_detected after 50 cycles.
  - stop_debug=1 the next cycle, then a full dump.
  - REG section words match the model: debug_addr steps 0..31, MEM section steps 0..15.
- Halt without dump: send 'c', then 'h' -> stop_debug=1, zero tx_start pulses.
  - Same cycle 'h' + halt_detected -> a dump occurs.
- Handshake/backpressure: tx_done withheld 1000 cycles -> no new tx_start and tx_data stable.
  - Spurious tx_done in SETUP/WAIT -> no byte skipped (byte count still 228).
  - Commands sent during the dump are ignored.
- Reset mid-dump: reset at byte 100 -> tx_start low immediately.
  - After release, 'd' produces a fresh dump starting at the PC word, 228 bytes.
